expr_tx: RTL and testbench

- Transmitter counterpart to the expression recogniser: serialises a latched operand/operator set into an ASCII byte stream of the form digit (op digit)*.
- One character is emitted per accepted transfer over a valid/ready handshake, with a last flag on the final character.
- Sits upstream of the recogniser's 8-bit `in` bus, driving stimulus and reference traffic.
- Every stream it emits is accepted by that recogniser.

---
 rtl/expr_tx_if.sv | 21 ++
 rtl/expr_tx.sv | 154 +++++++++++++++
 tb/tb_expr_tx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/expr_tx_if.sv
// rtl/expr_tx_if.sv - character stream bundle between expr_tx and its sink
interface expr_tx_if;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       last;

    modport master (
        output out,
        output out_valid,
        output last,
        input  out_ready
    );

    modport slave (
        input  out,
        input  out_valid,
        input  last,
        output out_ready
    );
endinterface

// File: rtl/expr_tx.sv
// rtl/expr_tx.sv - serialises a latched operand/operator set as ASCII "d(op d)*"
module expr_tx #(
    parameter int MAX_TERMS = 8
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [3:0]             num_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    output logic                   busy,
    output logic                   err,
    expr_tx_if.master              tx
);
    typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;

    localparam logic [3:0] MAX_T4   = 4'(MAX_TERMS);
    localparam int         DIG_PAD  = 64 - 4*MAX_TERMS;
    localparam int         OPS_PAD  = 17 - MAX_TERMS;

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [3:0]             nterms_q, nterms_d;
    logic [4*MAX_TERMS-1:0] digits_q, digits_d;
    logic [MAX_TERMS-2:0]   ops_q, ops_d;
    logic [7:0]             out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    // Latched operands padded to 16 entries so a 4-bit idx indexes them exactly.
    logic [63:0] digits_ext;
    logic [15:0] ops_ext;
    logic [3:0]  idx_inc;
    logic        req_ok;

    assign digits_ext = {{DIG_PAD{1'b0}}, digits_q};
    assign ops_ext    = {{OPS_PAD{1'b0}}, ops_q};
    assign idx_inc    = idx_q + 4'd1;

    // Request check: term count in range and every used operand is a BCD digit.
    always_comb begin
        req_ok = (num_terms != 4'd0) && (num_terms <= MAX_T4);
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((i < int'(num_terms)) && (digits[4*i +: 4] > 4'd9)) begin
                req_ok = 1'b0;
            end
        end
    end

    // Next-state and next-output decode; outputs are registered so nothing
    // reaches a port combinationally from start or out_ready.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nterms_d    = nterms_q;
        digits_d    = digits_q;
        ops_d       = ops_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        busy_d      = busy_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                out_d       = 8'h00;
                out_valid_d = 1'b0;
                last_d      = 1'b0;
                busy_d      = 1'b0;
                if (start) begin
                    if (req_ok) begin
                        state_d     = DIGIT;
                        idx_d       = 4'd0;
                        nterms_d    = num_terms;
                        digits_d    = digits;
                        ops_d       = ops;
                        out_d       = 8'h30 + {4'h0, digits[3:0]};
                        out_valid_d = 1'b1;
                        last_d      = (num_terms == 4'd1);
                        busy_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (tx.out_ready) begin
                    if (last_q) begin
                        // Final character taken; a coincident start is dropped.
                        state_d     = IDLE;
                        out_d       = 8'h00;
                        out_valid_d = 1'b0;
                        last_d      = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = OP;
                        out_d   = ops_ext[idx_q] ? 8'h2A : 8'h2B;
                        last_d  = 1'b0;
                    end
                end
            end
            OP: begin
                if (tx.out_ready) begin
                    state_d = DIGIT;
                    idx_d   = idx_inc;
                    out_d   = 8'h30 + {4'h0, digits_ext[{idx_inc, 2'b00} +: 4]};
                    last_d  = (idx_inc == (nterms_q - 4'd1));
                end
            end
            default: begin
                state_d     = IDLE;
                out_d       = 8'h00;
                out_valid_d = 1'b0;
                last_d      = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, latched request and registered outputs; clr_n abandons any stream.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            nterms_q    <= 4'd0;
            digits_q    <= '0;
            ops_q       <= '0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nterms_q    <= nterms_d;
            digits_q    <= digits_d;
            ops_q       <= ops_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign tx.out       = out_q;
    assign tx.out_valid = out_valid_q;
    assign tx.last      = last_q;
    assign busy         = busy_q;
    assign err          = err_q;
endmodule

// File: tb/tb_expr_tx.sv
// tb/tb_expr_tx.sv - self-checking bench for expr_tx
module tb_expr_tx;
    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [3:0]  num_terms;
    logic [31:0] digits;
    logic [6:0]  ops;
    logic        busy;
    logic        err;
    int          n_cmp = 0;
    int          n_bad = 0;

    expr_tx_if bus();

    expr_tx #(.MAX_TERMS(8)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .num_terms (num_terms),
        .digits    (digits),
        .ops       (ops),
        .busy      (busy),
        .err       (err),
        .tx        (bus.master)
    );

    always #5 clk = ~clk;

    // Issue one request and follow the stream it should produce, beat by beat.
    task automatic send(input int n, input logic [31:0] dg, input logic [6:0] op,
                        input int rdy_pct, input int stall_k, input int stall_n,
                        input int start_mask, output int beats);
        logic [7:0] q[$];
        int         len, k, cyc, stalls;
        logic       exp_last;
        logic [3:0] dv;
        q = {};
        for (int i = 0; i < n; i++) begin
            dv = dg[4*i +: 4];
            q.push_back(8'h30 + {4'h0, dv});
            if (i < n - 1) q.push_back(op[i] ? 8'h2A : 8'h2B);
        end
        len = q.size();
        start = 1'b1; num_terms = 4'(n); digits = dg; ops = op;
        @(negedge clk);
        start = 1'b0; digits = $urandom; ops = 7'($urandom); num_terms = 4'($urandom);
        k = 0; cyc = 0; stalls = 0; beats = 0;
        while (k < len && cyc < 300) begin
            exp_last = (k == len - 1);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out !== q[k] || bus.last !== exp_last ||
                busy !== 1'b1 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL beat%0d: out=%h valid=%b last=%b busy=%b err=%b, expected out=%h valid=1 last=%b busy=1 err=0",
                         k, bus.out, bus.out_valid, bus.last, busy, err, q[k], exp_last);
            end
            if (k == stall_k && stalls < stall_n) begin
                bus.out_ready = 1'b0;
                stalls++;
            end else begin
                bus.out_ready = ($urandom_range(99) < rdy_pct);
            end
            start = start_mask[k];
            if (start) begin
                num_terms = 4'd1; digits = 32'h9;
            end
            @(negedge clk);
            start = 1'b0;
            if (bus.out_ready) begin
                k++;
                beats++;
            end
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (cyc >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: got %0d of %0d beats", k, len);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.last !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after: out=%h valid=%b last=%b busy=%b err=%b, expected all 0",
                     bus.out, bus.out_valid, bus.last, busy, err);
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0; start = 1'b0; num_terms = 4'd0; digits = '0; ops = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.last !== 1'b0 ||
            busy !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: out=%h valid=%b last=%b busy=%b err=%b, expected all 0",
                     bus.out, bus.out_valid, bus.last, busy, err);
        end
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ready: out=%h valid=%b busy=%b, expected 0", bus.out, bus.out_valid, busy);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_single();
        int b;
        send(1, 32'h7, 7'h0, 100, -1, 0, 0, b);
    endtask

    task automatic test_stream();
        int b;
        send(3, 32'h201, 7'b0000010, 100, -1, 0, 0, b);
    endtask

    task automatic test_backpressure();
        int b;
        send(3, 32'h201, 7'b0000010, 100, 1, 3, 0, b);
        n_cmp++;
        if (b !== 5) begin
            n_bad++;
            $display("FAIL bp_count: transfers=%0d expected 5", b);
        end
    endtask

    task automatic test_invalid();
        for (int t = 0; t < 3; t++) begin
            start = 1'b1;
            case (t)
                0: begin num_terms = 4'd0; digits = 32'h1; end
                1: begin num_terms = 4'd2; digits = 32'hA3; end
                default: begin num_terms = 4'd9; digits = 32'h0; end
            endcase
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (err !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL invalid%0d: err=%b valid=%b busy=%b, expected err=1 valid=0 busy=0",
                         t, err, bus.out_valid, busy);
            end
            @(negedge clk);
            n_cmp++;
            if (err !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL invalid_pulse%0d: err=%b valid=%b busy=%b, expected all 0",
                         t, err, bus.out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        start = 1'b1; num_terms = 4'd3; digits = 32'h201; ops = 7'b0000010;
        @(negedge clk);
        start = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out !== 8'h2A || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: out=%h valid=%b expected 2a 1", bus.out, bus.out_valid);
        end
        #2 clr_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out !== 8'h00 || bus.last !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: out=%h valid=%b busy=%b last=%b expected all 0",
                     bus.out, bus.out_valid, busy, bus.last);
        end
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        send(1, 32'h5, 7'h0, 100, -1, 0, 0, b);
    endtask

    task automatic test_start_busy();
        int b;
        send(3, 32'h201, 7'b0000010, 100, -1, 0, (1 << 2) | (1 << 4), b);
        send(2, 32'h38, 7'b0000001, 100, -1, 0, 0, b);
    endtask

    task automatic test_random();
        int          b, n;
        logic [31:0] dg;
        logic [6:0]  op;
        for (int t = 0; t < 25; t++) begin
            n  = $urandom_range(8, 1);
            dg = '0;
            for (int i = 0; i < 8; i++) begin
                dg[4*i +: 4] = (i < n) ? 4'($urandom_range(9)) : 4'($urandom_range(15));
            end
            op = 7'($urandom);
            send(n, dg, op, $urandom_range(100, 30), -1, 0, 0, b);
            n_cmp++;
            if (b !== 2*n - 1) begin
                n_bad++;
                $display("FAIL rand_len%0d: transfers=%0d expected %0d", t, b, 2*n - 1);
            end
            if ($urandom_range(1)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int b;
        for (int t = 0; t < 4; t++) begin
            send(2, 32'h00000094 + t, 7'(t), 100, -1, 0, 0, b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_start_busy();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
